generador_tick_vel: RTL and testbench
=====================================

GENERADOR_TICK_VEL -- requirements
Module: generador_tick_vel

Interface
REQ-001 Parameter BASE_DIV, default 2500000, clock cycles per speed unit; minimum 1.
REQ-002 Parameter DEB_CYCLES, default 500000, consecutive stable cycles required to accept a key level; minimum 1.
REQ-003 Parameter VEL_RST, default 3, speed level loaded at reset; range 0..7.
REQ-004 CLK  input  1  system clock (50 MHz on board); the only clock.
REQ-005 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-006 KEY  input  3  raw active-low push-buttons, asynchronous to CLK: KEY[0] speed up, KEY[1] speed down, KEY[2] pause toggle.
REQ-007 SW   input  2  SW[0] run enable (1 = run); SW[1] turbo (1 = halve tick period).
REQ-008 TICK  output  1  one-cycle step pulse consumed by juego_luces_vel_var as its ENABLE.
REQ-009 VEL   output  3  current speed level, 0 = slowest, 7 = fastest.
REQ-010 PAUSA output  1  1 while pause is latched.

Function
REQ-011 Each KEY bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 The debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any shorter glitch resets the stability count.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; release generates no event; holding a key SHALL yield exactly one event.
REQ-014 Press-to-event latency SHALL be exactly 2 + DEB_CYCLES + 1 cycles from the first low sample of a clean press.
REQ-015 An up event SHALL increment VEL, saturating at 7; a down event SHALL decrement VEL, saturating at 0.
REQ-016 Up and down events in the same cycle SHALL leave VEL unchanged.
REQ-017 A pause event SHALL toggle PAUSA.
REQ-018 Base period P SHALL be BASE_DIV*(8-VEL) cycles; with SW[1]=1, P SHALL be max(1, P>>1).
REQ-019 The period counter SHALL be sized for BASE_DIV*8 without overflow.
REQ-020 Running SHALL be defined as SW[0]=1 and PAUSA=0.
REQ-021 While running, the period counter SHALL count 0..P-1; TICK SHALL be 1 in the cycle the counter equals P-1, and the counter SHALL then return to 0; consecutive TICKs are exactly P cycles apart.
REQ-022 While not running, TICK SHALL be 0 and the counter SHALL hold its value; resumption SHALL continue from the held count.
REQ-023 Any change of VEL or SW[1] SHALL clear the counter to 0 in the following cycle, with no TICK in that cycle.
REQ-024 TICK SHALL be registered (no combinational path from KEY or SW).

Reset
REQ-025 With RST=1 at a rising edge: VEL=VEL_RST, PAUSA=0, TICK=0, period counter=0, debounced levels=1 (released), stability counters=0, synchronizers=1.
REQ-026 RST asserted mid-period or mid-debounce SHALL discard all partial state; no TICK or event SHALL be emitted in the cycle after reset release.

Structure
REQ-027 Constants NUM_VEL=8, VEL_W=3 and default VEL_RST SHALL reside in the shared project constants include/package.
REQ-028 The synchronizer, debounce and edge logic SHALL be one sub-module, antirrebote (1-bit, parameter DEB_CYCLES), instantiated three times.
REQ-029 The speed register, pause flag and period counter SHALL reside in the top module; total RTL 120-400 lines.

Verification (BASE_DIV=4, DEB_CYCLES=3, VEL_RST=3, SW=01 unless stated)
REQ-030 Release RST with KEY=111 -> VEL=3, PAUSA=0; TICK pulses every 20 cycles, first TICK 20 cycles after reset release.
REQ-031 KEY[0] low for 10 cycles -> a single event 6 cycles after the first low sample; VEL=4; counter clears; TICK then every 16 cycles.
REQ-032 KEY[0] low for 2 cycles, then high (bounce) -> no event; VEL stays 3; TICK spacing unchanged at 20.
REQ-033 Six clean KEY[0] presses -> VEL saturates at 7, P=4; then SW[1]=1 -> P=2, TICK every 2 cycles; nine KEY[1] presses -> VEL=0, P=16 (turbo).
REQ-034 KEY[2] press -> PAUSA=1, no TICK and counter frozen; second press -> PAUSA=0 and TICK resumes from the held count; identical freeze/resume behaviour with SW[0]=0.
REQ-035 Simultaneous clean presses of KEY[0] and KEY[1] -> VEL unchanged; RST asserted mid-period -> next TICK exactly 20 cycles after release.

Source files
------------

// File: rtl/generador_tick_vel_pkg.sv
// -----------------------------------------------------------------------------
// generador_tick_vel_pkg
// Shared constants and helpers for the speed-controlled tick generator.
//   NUM_VEL / VEL_W / VEL_RST_DEF : speed level range and default level.
//   KEY_* / SW_* indices          : bit positions of the board inputs.
//   vel_next()                    : saturating speed update from up/down events.
// -----------------------------------------------------------------------------
package generador_tick_vel_pkg;

   localparam int NUM_VEL     = 8;
   localparam int VEL_W       = 3;
   localparam int VEL_RST_DEF = 3;
   localparam int NUM_KEYS    = 3;

   localparam int KEY_UP    = 0;
   localparam int KEY_DN    = 1;
   localparam int KEY_PAUSE = 2;
   localparam int SW_RUN    = 0;
   localparam int SW_TURBO  = 1;

   localparam logic [VEL_W-1:0] VEL_MAX = 3'd7;
   localparam logic [VEL_W-1:0] VEL_MIN = 3'd0;

   typedef enum logic [1:0] {
      VEL_HOLD = 2'd0,
      VEL_INC  = 2'd1,
      VEL_DEC  = 2'd2
   } vel_act_e;

   // Up and down together cancel out; both directions saturate at the range ends.
   function automatic logic [VEL_W-1:0] vel_next(input logic [VEL_W-1:0] vel,
                                                  input logic up,
                                                  input logic dn);
      vel_act_e         act;
      logic [VEL_W-1:0] res;
      case ({up, dn})
         2'b10:   act = VEL_INC;
         2'b01:   act = VEL_DEC;
         default: act = VEL_HOLD;
      endcase
      case (act)
         VEL_INC: res = (vel == VEL_MAX) ? vel : vel + 3'd1;
         VEL_DEC: res = (vel == VEL_MIN) ? vel : vel - 3'd1;
         default: res = vel;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/generador_tick_vel_if.sv
// -----------------------------------------------------------------------------
// generador_tick_vel_if
// Board-side signals of the tick generator.
//   KEY[2:0] : raw active-low buttons (up, down, pause)
//   SW[1:0]  : run enable, turbo
//   TICK     : one-cycle step pulse
//   VEL      : current speed level
//   PAUSA    : pause latched
// master = stimulus side, slave = generator side.
// -----------------------------------------------------------------------------
interface generador_tick_vel_if;
   import generador_tick_vel_pkg::*;

   logic [NUM_KEYS-1:0] KEY;
   logic [1:0]          SW;
   logic                TICK;
   logic [VEL_W-1:0]    VEL;
   logic                PAUSA;

   modport master (output KEY, output SW, input TICK, input VEL, input PAUSA);
   modport slave  (input KEY, input SW, output TICK, output VEL, output PAUSA);

endinterface

// File: rtl/generador_tick_vel_antirrebote.sv
// -----------------------------------------------------------------------------
// antirrebote
// One push-button channel: 2-flop synchronizer, debounce and press detection.
//   clk, rst : system clock, synchronous active-high reset
//   key_n    : raw active-low button, asynchronous to clk
//   press    : one-cycle pulse on the debounced 1->0 transition
// Latency from the first edge that samples a clean low level to press high is
// 2 (synchronizer) + DEB_CYCLES (stability) + 1 (edge register) cycles.
// -----------------------------------------------------------------------------
module antirrebote
   import generador_tick_vel_pkg::*;
#(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             deb_q, deb_d;
   logic             deb_prev_q, deb_prev_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: the stability count runs only while the synchronized level
   // disagrees with the accepted one, so any glitch restarts it from zero.
   always_comb begin
      sync1_d    = key_n;
      sync2_d    = sync1_q;
      deb_d      = deb_q;
      cnt_d      = CNT_ZERO;
      deb_prev_d = deb_q;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = CNT_ZERO;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = CNT_ZERO;
      end
      // Only the press edge matters; a release is silently absorbed.
      press_d = deb_prev_q & ~deb_q;
   end

   // State registers; reset leaves the channel in the released state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         deb_q      <= 1'b1;
         deb_prev_q <= 1'b1;
         cnt_q      <= CNT_ZERO;
         press_q    <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/generador_tick_vel.sv
// -----------------------------------------------------------------------------
// generador_tick_vel
// Speed-controlled step pulse generator for the light game.
//   CLK, RST : system clock, synchronous active-high reset
//   bus      : KEY/SW inputs, TICK/VEL/PAUSA outputs (slave modport)
// Tick period is BASE_DIV*(8-VEL) cycles, halved (minimum 1) in turbo mode.
// The period counter holds while stopped and restarts from zero whenever the
// speed or the turbo setting changes.
// -----------------------------------------------------------------------------
module generador_tick_vel
   import generador_tick_vel_pkg::*;
#(
   parameter int BASE_DIV   = 2500000,
   parameter int DEB_CYCLES = 500000,
   parameter int VEL_RST    = VEL_RST_DEF
) (
   input  logic                       CLK,
   input  logic                       RST,
   generador_tick_vel_if.slave        bus
);

   localparam int CNT_W = $clog2(BASE_DIV * NUM_VEL + 1);
   localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_DIV);
   localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(32'd1);

   logic [NUM_KEYS-1:0] press_s;
   logic [VEL_W-1:0]    vel_q, vel_d;
   logic                pausa_q, pausa_d;
   logic                turbo_q, turbo_d;
   logic                tick_q, tick_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    span_s, base_s, period_s;
   logic                running_s, clear_s;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote (
         .clk   (CLK),
         .rst   (RST),
         .key_n (bus.KEY[i]),
         .press (press_s[i])
      );
   end

   // Period selection from the registered speed and turbo state.
   always_comb begin
      span_s = CNT_W'(4'd8 - {1'b0, vel_q});
      base_s = BASE_C * span_s;
      if (turbo_q) begin
         if (base_s > ONE_C) begin
            period_s = {1'b0, base_s[CNT_W-1:1]};
         end else begin
            period_s = ONE_C;
         end
      end else begin
         period_s = base_s;
      end
   end

   // Speed, pause and period counter next-state.
   always_comb begin
      vel_d     = vel_next(vel_q, press_s[KEY_UP], press_s[KEY_DN]);
      pausa_d   = pausa_q ^ press_s[KEY_PAUSE];
      turbo_d   = bus.SW[SW_TURBO];
      running_s = bus.SW[SW_RUN] & ~pausa_q;
      clear_s   = (vel_d != vel_q) | (turbo_d != turbo_q);
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      // A period change wins over counting so the new period starts cleanly.
      if (clear_s) begin
         cnt_d = ZERO_C;
      end else if (running_s) begin
         if (cnt_q >= period_s - ONE_C) begin
            cnt_d  = ZERO_C;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE_C;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers; turbo is loaded from the switch so leaving reset does
   // not look like a turbo change.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vel_q   <= VEL_W'(VEL_RST);
         pausa_q <= 1'b0;
         turbo_q <= bus.SW[SW_TURBO];
         tick_q  <= 1'b0;
         cnt_q   <= ZERO_C;
      end else begin
         vel_q   <= vel_d;
         pausa_q <= pausa_d;
         turbo_q <= turbo_d;
         tick_q  <= tick_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.TICK  = tick_q;
   assign bus.VEL   = vel_q;
   assign bus.PAUSA = pausa_q;

endmodule

// File: tb/tb_generador_tick_vel.sv
// -----------------------------------------------------------------------------
// tb_generador_tick_vel
// Scoreboard bench: expected TICK cycles are queued as stimulus is applied and
// popped by a monitor whenever TICK is seen. VEL/PAUSA are checked at the
// exact cycles where a key press must take effect.
// -----------------------------------------------------------------------------
module tb_generador_tick_vel;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   generador_tick_vel_if bus_if();

   generador_tick_vel #(
      .BASE_DIV   (4),
      .DEB_CYCLES (3),
      .VEL_RST    (3)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int next_t;
   int per;
   int mv;
   bit mp;
   bit turbo;
   bit frozen;
   int freeze_k;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int period(input int v, input bit t);
      int p;
      p = 4 * (8 - v);
      if (t) p = p >> 1;
      if (p < 1) p = 1;
      return p;
   endfunction

   task automatic extend(input int upto);
      if (!frozen) begin
         while (next_t <= upto) begin
            exp_q.push_back(next_t);
            next_t += per;
         end
      end
   endtask

   task automatic wait_to(input int c);
      extend(c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_rel(input int n);
      wait_to(cyc + n);
   endtask

   task automatic change(input int chg, input int p);
      extend(chg - 1);
      per    = p;
      next_t = chg + p;
   endtask

   // Monitor: every TICK must match the head of the expected queue.
   always @(negedge clk) begin
      if (bus_if.TICK) begin
         if (exp_q.size() == 0) check_val("tick_unexpected", cyc, -1);
         else                   check_val("tick_time", cyc, exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
         check_val("tick_missing", cyc, exp_q.pop_front());
      end
   end

   task automatic press(input logic [2:0] mask, input int hold);
      int s, chg, nv;
      bit np;
      s   = cyc;
      chg = s + 7;
      nv  = mv;
      if (mask[0] && !mask[1] && mv < 7) nv = mv + 1;
      else if (mask[1] && !mask[0] && mv > 0) nv = mv - 1;
      np = mp ^ mask[2];
      bus_if.KEY = ~mask;
      if (nv != mv) change(chg, period(nv, turbo));
      if (mask[2]) begin
         if (!mp) begin
            extend(chg);
            frozen   = 1'b1;
            freeze_k = s + 1;
         end else begin
            next_t += (s + 1 - freeze_k);
            frozen  = 1'b0;
         end
      end
      wait_to(chg - 1);
      check_val("vel_before", int'(bus_if.VEL), mv);
      check_val("pausa_before", int'(bus_if.PAUSA), int'(mp));
      wait_to(chg);
      check_val("vel_after", int'(bus_if.VEL), nv);
      check_val("pausa_after", int'(bus_if.PAUSA), int'(np));
      mv = nv;
      mp = np;
      wait_to(s + hold);
      bus_if.KEY = 3'b111;
      wait_rel(6);
   endtask

   task automatic set_turbo(input bit t);
      int s;
      s = cyc;
      bus_if.SW[1] = t;
      change(s + 1, period(mv, t));
      turbo = t;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, s;
      bus_if.KEY = 3'b111;
      bus_if.SW  = 2'b01;
      rst    = 1'b1;
      frozen = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_vel", int'(bus_if.VEL), 3);
      check_val("rst_pausa", int'(bus_if.PAUSA), 0);
      check_val("rst_tick", int'(bus_if.TICK), 0);

      // Release reset: first tick 20 cycles later, then every 20.
      rst    = 1'b0;
      r      = cyc;
      mv     = 3;
      mp     = 1'b0;
      turbo  = 1'b0;
      per    = 20;
      next_t = r + 20;
      frozen = 1'b0;
      wait_to(r + 60);

      // Short bounce on KEY[0]: no event, schedule untouched.
      bus_if.KEY[0] = 1'b0;
      wait_rel(2);
      bus_if.KEY[0] = 1'b1;
      wait_rel(14);
      check_val("bounce_vel", int'(bus_if.VEL), 3);
      wait_rel(20);

      // Held press: single event, VEL=4, period 16.
      press(3'b001, 10);
      wait_rel(40);

      // Up to saturation at 7 (period 4), two saturating presses included.
      repeat (5) press(3'b001, 8);
      check_val("vel_sat_hi", int'(bus_if.VEL), 7);
      wait_rel(12);

      // Turbo: period 2.
      set_turbo(1'b1);
      wait_rel(10);

      // Down to 0 with saturation: turbo period 16.
      repeat (9) press(3'b010, 8);
      check_val("vel_sat_lo", int'(bus_if.VEL), 0);
      wait_rel(40);

      set_turbo(1'b0);
      wait_rel(40);

      // Simultaneous up/down: no change, no clear.
      press(3'b011, 8);
      wait_rel(40);

      // Pause and resume from the held count.
      press(3'b100, 8);
      wait_rel(40);
      press(3'b100, 8);
      wait_rel(40);

      // Run switch off: same freeze/resume behaviour.
      s = cyc;
      extend(s);
      bus_if.SW[0] = 1'b0;
      frozen = 1'b1;
      repeat (25) @(negedge clk);
      check_val("sw_off_pausa", int'(bus_if.PAUSA), 0);
      next_t += cyc - s;
      frozen = 1'b0;
      bus_if.SW[0] = 1'b1;
      wait_rel(40);

      press(3'b001, 8);
      wait_rel(10);

      // Reset mid-period and mid-debounce: partial state discarded.
      bus_if.KEY[0] = 1'b0;
      wait_rel(3);
      s = cyc;
      extend(s);
      frozen = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus_if.KEY = 3'b111;
      r      = cyc;
      mv     = 3;
      mp     = 1'b0;
      per    = period(3, turbo);
      next_t = r + per;
      frozen = 1'b0;
      check_val("rst2_vel", int'(bus_if.VEL), 3);
      wait_to(r + 60);
      check_val("rst2_vel_hold", int'(bus_if.VEL), 3);

      @(negedge clk);
      check_val("ticks_pending", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
